// File: rtl/block_output_if.sv
// Link bundle between the input blocks, one router output port and the neighbour router.
// master = input blocks plus neighbour side, slave = the output port itself.
interface block_output_if #(
  parameter int unsigned NPORT = 5
);
  logic [NPORT-1:0]   req;
  logic [NPORT*8-1:0] Data_in;
  logic [NPORT-1:0]   grant;
  logic [NPORT-1:0]   in_ack;
  logic               val;
  logic [7:0]         Data_out;
  logic               ret;

  modport master (
    output req, Data_in, ret,
    input  grant, in_ack, val, Data_out
  );

  modport slave (
    input  req, Data_in, ret,
    output grant, in_ack, val, Data_out
  );
endinterface

// File: rtl/block_output.sv
// Router output port: round-robin wormhole arbiter over the input blocks
// feeding a small flit FIFO that drives the val/ret link.
module block_output #(
  parameter int unsigned NPORT   = 5,
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned DEPTH   = 4
) (
  input logic           clk,
  input logic           rst,
  block_output_if.slave bus
);
  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NPORT-1:0] in_ack;

  logic [7:0]       mem [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             empty, full, push, pop;
  logic [7:0]       din;
  logic             found;
  int unsigned      idx;

  // Extra pointer bit separates full from empty when the indices match
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign din   = bus.Data_in[8*owner_q +: 8];
  assign push  = (state_q == BUSY) && grant_q[owner_q] && bus.req[owner_q] && !full;
  assign pop   = !empty && bus.ret;

  assign bus.grant    = grant_q;
  assign bus.in_ack   = in_ack;
  assign bus.val      = !empty;
  assign bus.Data_out = empty ? 8'h00 : mem[rd_q[AW-1:0]];

  // Next-state: arbitrate in IDLE, stream one packet from the owner in BUSY
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    in_ack  = '0;
    found   = 1'b0;
    idx     = 0;
    case (state_q)
      IDLE: begin
        for (int unsigned k = 1; k <= NPORT; k++) begin
          if (!found && bus.req[(32'(last_q) + k) % NPORT]) begin
            found = 1'b1;
            idx   = (32'(last_q) + k) % NPORT;
          end
        end
        if (found) begin
          owner_d          = PW'(idx);
          grant_d          = '0;
          grant_d[owner_d] = 1'b1;
          cnt_d            = '0;
          state_d          = BUSY;
        end
      end
      BUSY: begin
        if (push) begin
          in_ack[owner_q] = 1'b1;
          cnt_d           = cnt_q + 4'd1;
          if (cnt_q == CW'(PKT_LEN - 1)) begin
            grant_d = '0;
            last_d  = owner_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= PW'(NPORT - 1);
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset; contents are only visible while non-empty
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: tb/tb_block_output.sv
// Randomised and directed bench for block_output against a queue-based packet model.
module tb_block_output;
  localparam int unsigned NPORT   = 5;
  localparam int unsigned PKT_LEN = 4;
  localparam int unsigned DEPTH   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_output_if #(.NPORT(NPORT)) bus();

  block_output #(.NPORT(NPORT), .PKT_LEN(PKT_LEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus state: flits still to offer per port, next flit value, stall mask
  int               pend [NPORT];
  int               sent [NPORT];
  logic [7:0]       next_flit [NPORT];
  logic [NPORT-1:0] stall;
  logic             ret_v, rst_v;
  bit               rand_data, chk_en;

  // Reference model: current owner (-1 none), flits in packet, last owner, FIFO contents
  int         m_owner, m_cnt, m_last;
  logic [7:0] m_q [$];

  logic [NPORT-1:0] owners_q [$];
  logic [7:0]       out_q [$];
  logic [NPORT-1:0] prev_grant, obs_grant, obs_ack;
  logic             obs_val;
  logic [7:0]       obs_dout;

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = NPORT - 1;
    m_q.delete();
  endtask

  task automatic cycle();
    logic [NPORT-1:0] r, eg, ea;
    bit               push, pop;
    logic [7:0]       ed, flit;
    @(negedge clk);
    for (int i = 0; i < NPORT; i++) begin
      r[i] = (pend[i] > 0) && !stall[i];
      bus.Data_in[8*i +: 8] = next_flit[i];
    end
    bus.req = r;
    bus.ret = ret_v;
    rst     = rst_v;
    #1;
    eg   = (m_owner >= 0) ? (NPORT'(1) << m_owner) : '0;
    push = (m_owner >= 0) && r[m_owner] && (m_q.size() < DEPTH);
    ea   = push ? eg : '0;
    ed   = (m_q.size() > 0) ? m_q[0] : 8'h00;
    obs_grant = bus.grant;
    obs_ack   = bus.in_ack;
    obs_val   = bus.val;
    obs_dout  = bus.Data_out;
    if (chk_en) begin
      check("grant", 32'(bus.grant), 32'(eg));
      check("in_ack", 32'(bus.in_ack), 32'(ea));
      check("val", 32'(bus.val), 32'(m_q.size() > 0));
      check("data_out", 32'(bus.Data_out), 32'(ed));
    end
    if (bus.grant != '0 && prev_grant == '0) owners_q.push_back(bus.grant);
    prev_grant = bus.grant;
    if (bus.val && ret_v && !rst_v) out_q.push_back(bus.Data_out);
    @(posedge clk);
    if (rst_v) begin
      model_reset();
    end else begin
      pop = (m_q.size() > 0) && ret_v;
      if (pop) void'(m_q.pop_front());
      if (m_owner >= 0) begin
        if (push) begin
          flit = next_flit[m_owner];
          m_q.push_back(flit);
          pend[m_owner]--;
          sent[m_owner]++;
          next_flit[m_owner] = rand_data ? 8'($urandom) : next_flit[m_owner] + 8'd1;
          m_cnt++;
          if (m_cnt == PKT_LEN) begin
            m_last  = m_owner;
            m_owner = -1;
          end
        end
      end else begin
        for (int k = 1; k <= int'(NPORT); k++) begin
          if (m_owner < 0 && r[(m_last + k) % int'(NPORT)]) begin
            m_owner = (m_last + k) % int'(NPORT);
            m_cnt   = 0;
          end
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Two reset edges with random req/data/ret, then a clean idle environment
  task automatic do_reset();
    rst_v = 1'b1;
    ret_v = 1'($urandom);
    for (int i = 0; i < NPORT; i++) begin
      pend[i]      = int'($urandom_range(0, 1));
      next_flit[i] = 8'($urandom);
    end
    stall = '0;
    cycle();
    chk_en = 1'b1;
    cycle();
    rst_v = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      pend[i] = 0;
      sent[i] = 0;
    end
    out_q.delete();
    owners_q.delete();
  endtask

  task automatic wait_sent(input int port, input int n, input string tag);
    int budget = 20;
    while (sent[port] < n && budget > 0) begin
      cycle();
      budget--;
    end
    check(tag, 32'(sent[port] >= n), 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp [$]);
    check({tag, "_count"}, 32'(out_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_q.size(); i++)
      check(tag, 32'(out_q[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp [$];
    rst = 1'b1;
    bus.req = '0;
    bus.Data_in = '0;
    bus.ret = 1'b0;
    rand_data = 1'b0;
    chk_en = 1'b0;
    prev_grant = '0;
    model_reset();

    // T1 + T2: single packet after reset
    do_reset();
    next_flit[0] = 8'hA1;
    pend[0] = 4;
    ret_v = 1'b1;
    run(8);
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    check_out("t2_flits", exp);
    check("t2_owner", 32'(owners_q.size() > 0 ? owners_q[0] : '0), 32'h01);

    // T3: round-robin between ports 0 and 2
    do_reset();
    next_flit[0] = 8'h01;
    next_flit[2] = 8'h21;
    pend[0] = 8;
    pend[2] = 4;
    ret_v = 1'b1;
    run(20);
    check("t3_npkts", 32'(owners_q.size()), 32'd3);
    if (owners_q.size() == 3) begin
      check("t3_own0", 32'(owners_q[0]), 32'h01);
      check("t3_own1", 32'(owners_q[1]), 32'h04);
      check("t3_own2", 32'(owners_q[2]), 32'h01);
    end

    // T4: backpressure fills the FIFO, then drains in order
    do_reset();
    next_flit[0] = 8'hB1;
    next_flit[1] = 8'hB5;
    pend[0] = 4;
    pend[1] = 4;
    ret_v = 1'b0;
    run(8);
    check("t4_full_ack", 32'(obs_ack), 32'h0);
    check("t4_full_val", 32'(obs_val), 32'h1);
    check("t4_full_head", 32'(obs_dout), 32'hB1);
    ret_v = 1'b1;
    run(16);
    exp.delete();
    for (int i = 0; i < 8; i++) exp.push_back(8'hB1 + 8'(i));
    check_out("t4_flits", exp);

    // T5: owner stalls mid-packet while port 3 waits
    do_reset();
    next_flit[1] = 8'h11;
    next_flit[3] = 8'h31;
    pend[1] = 4;
    pend[3] = 4;
    ret_v = 1'b1;
    wait_sent(1, 2, "t5_two_flits");
    stall[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_hold_grant", 32'(obs_grant), 32'h02);
      check("t5_hold_ack", 32'(obs_ack), 32'h0);
    end
    stall = '0;
    run(14);
    check("t5_npkts", 32'(owners_q.size()), 32'd2);
    if (owners_q.size() == 2) check("t5_next_owner", 32'(owners_q[1]), 32'h08);
    exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h31, 8'h32, 8'h33, 8'h34};
    check_out("t5_flits", exp);

    // T6: reset in the middle of a port 4 packet
    do_reset();
    next_flit[4] = 8'h41;
    pend[4] = 4;
    ret_v = 1'b1;
    wait_sent(4, 2, "t6_two_flits");
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
    owners_q.delete();
    next_flit[0] = 8'h51;
    pend[0] = 4;
    pend[4] = 4;
    cycle();
    check("t6_rst_grant", 32'(obs_grant), 32'h0);
    check("t6_rst_val", 32'(obs_val), 32'h0);
    check("t6_rst_dout", 32'(obs_dout), 32'h0);
    run(6);
    check("t6_first_owner", 32'(owners_q.size() > 0 ? owners_q[0] : '0), 32'h01);

    // Random traffic, backpressure, stalls and occasional resets
    do_reset();
    rand_data = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NPORT; i++)
        if (pend[i] == 0 && $urandom_range(0, 9) == 0) pend[i] = PKT_LEN * int'($urandom_range(1, 2));
      stall = ($urandom_range(0, 7) == 0) ? NPORT'($urandom) : '0;
      ret_v = ($urandom_range(0, 9) < 7);
      rst_v = ($urandom_range(0, 299) == 0);
      cycle();
      if (rst_v) begin
        rst_v = 1'b0;
        for (int i = 0; i < NPORT; i++) pend[i] = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
